// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock divider.
package clk_div_pkg;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, shadowed divisor/mode, registered outputs.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int                 WIDTH       = 16,
  parameter logic [WIDTH-1:0]   DEFAULT_DIV = WIDTH'(6)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] div,
  input  logic             mode,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] act_div;
  logic [WIDTH-1:0] shd_div;
  mode_e            act_mode;
  mode_e            shd_mode;

  logic             boundary;
  logic             apply;
  logic [WIDTH-1:0] new_div;
  mode_e            new_mode;

  // A LOAD in the current cycle bypasses the shadow so it can land on this edge.
  always_comb begin
    new_div  = load ? div : shd_div;
    new_mode = load ? mode_e'(mode) : shd_mode;
    boundary = en && (act_div != '0) && (cnt == act_div - ONE);
    apply    = (load || pending) && (boundary || !en || (act_div == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      act_div  <= DEFAULT_DIV;
      act_mode <= MODE_TOGGLE;
      shd_div  <= '0;
      shd_mode <= MODE_TOGGLE;
      clk_out  <= 1'b0;
      tick     <= 1'b0;
      pending  <= 1'b0;
    end else begin
      if (load) begin
        shd_div  <= div;
        shd_mode <= mode_e'(mode);
      end

      if (!en || (act_div == '0)) begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end else if (boundary) begin
        cnt     <= '0;
        tick    <= 1'b1;
        clk_out <= (act_mode == MODE_TOGGLE) ? ~clk_out : 1'b1;
      end else begin
        cnt  <= cnt + ONE;
        tick <= 1'b0;
        if (act_mode == MODE_PULSE) clk_out <= 1'b0;
      end

      // Any mode switch restarts the output from a known low level.
      if (apply) begin
        act_div  <= new_div;
        act_mode <= new_mode;
        cnt      <= '0;
        pending  <= 1'b0;
        if (new_mode != act_mode) clk_out <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N_CH independent programmable clock dividers; the top only slices buses.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int               N_CH        = 2,
  parameter int               WIDTH       = 16,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(6)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         en,
  input  logic [N_CH-1:0]         load,
  input  logic [N_CH*WIDTH-1:0]   div,
  input  logic [N_CH-1:0]         mode,
  output logic [N_CH-1:0]         clk_out,
  output logic [N_CH-1:0]         tick,
  output logic [N_CH-1:0]         pending
);

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      clk_div_chan #(
        .WIDTH      (WIDTH),
        .DEFAULT_DIV(DEFAULT_DIV)
      ) u_chan (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en[gi]),
        .load   (load[gi]),
        .div    (div[gi*WIDTH +: WIDTH]),
        .mode   (mode[gi]),
        .clk_out(clk_out[gi]),
        .tick   (tick[gi]),
        .pending(pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Self-checking bench for clk_div_multi: directed scenarios plus randomized run vs. a period-level model.
module tb_clk_div_multi;

  localparam int N_CH = 2;
  localparam int W    = 16;

  logic              clk;
  logic              rst_n;
  logic [N_CH-1:0]   en;
  logic [N_CH-1:0]   load;
  logic [N_CH*W-1:0] div;
  logic [N_CH-1:0]   mode;
  logic [N_CH-1:0]   clk_out;
  logic [N_CH-1:0]   tick;
  logic [N_CH-1:0]   pending;

  int checks   = 0;
  int failures = 0;

  clk_div_multi #(.N_CH(N_CH), .WIDTH(W), .DEFAULT_DIV(W'(6))) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .load   (load),
    .div    (div),
    .mode   (mode),
    .clk_out(clk_out),
    .tick   (tick),
    .pending(pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position within the period, number of completed periods
  // (toggle output = parity of that count), and the pending shadow.
  int m_pos [N_CH];
  int m_d   [N_CH];
  int m_per [N_CH];
  int m_sd  [N_CH];
  bit m_mode[N_CH];
  bit m_sm  [N_CH];
  bit m_tick[N_CH];
  bit m_pend[N_CH];
  bit m_fz  [N_CH];
  logic [N_CH-1:0] exp_out, exp_tick, exp_pend;

  always @(posedge clk or negedge rst_n) begin
    for (int c = 0; c < N_CH; c++) begin
      if (!rst_n) begin
        m_pos[c] = 0; m_d[c] = 6; m_per[c] = 0; m_sd[c] = 0;
        m_mode[c] = 0; m_sm[c] = 0; m_tick[c] = 0; m_pend[c] = 0; m_fz[c] = 0;
      end else begin
        bit e, l, bnd, stall;
        e     = en[c];
        l     = load[c];
        stall = !e || (m_d[c] == 0);
        bnd   = e && (m_d[c] > 0) && (m_pos[c] == m_d[c] - 1);
        if (l) begin
          m_sd[c] = int'(div[c*W +: W]);
          m_sm[c] = mode[c];
        end
        if (stall) begin
          m_pos[c] = 0; m_tick[c] = 0; m_per[c] = 0;
        end else if (bnd) begin
          m_pos[c] = 0; m_tick[c] = 1; m_per[c] = m_per[c] + 1;
        end else begin
          m_pos[c] = m_pos[c] + 1; m_tick[c] = 0;
        end
        m_fz[c] = 0;
        if ((l || m_pend[c]) && (bnd || stall)) begin
          if (m_sm[c] != m_mode[c]) begin
            m_per[c] = 0;
            m_fz[c]  = 1;
          end
          m_mode[c] = m_sm[c];
          m_d[c]    = m_sd[c];
          m_pos[c]  = 0;
          m_pend[c] = 0;
        end else if (l) begin
          m_pend[c] = 1;
        end
      end
      exp_tick[c] = m_tick[c];
      exp_pend[c] = m_pend[c];
      exp_out[c]  = m_mode[c] ? (m_tick[c] && !m_fz[c]) : ((m_per[c] % 2) != 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    load = '0;
  endtask

  task automatic apply_reset();
    en    = '0;
    load  = '0;
    rst_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    en = '0; load = '0; div = '0; mode = '0;
    rst_n = 1'b0;
    #2;
    checks++;
    if ({clk_out, tick, pending} !== '0) begin
      failures++;
      $display("FAIL reset_state got clk_out=%b tick=%b pending=%b want all 0", clk_out, tick, pending);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({clk_out, tick, pending} !== '0) begin
        failures++;
        $display("FAIL reset_idle got clk_out=%b tick=%b pending=%b want all 0", clk_out, tick, pending);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_default_toggle();
    apply_reset();
    en = 2'b11;
    for (int k = 1; k <= 48; k++) begin
      step();
      checks++;
      if (tick[0] !== (k % 6 == 0) || clk_out[0] !== ((k / 6) % 2 == 1)) begin
        failures++;
        $display("FAIL default_toggle edge %0d got tick=%b clk_out=%b want tick=%b clk_out=%b",
                 k, tick[0], clk_out[0], (k % 6 == 0), ((k / 6) % 2 == 1));
      end
      checks++;
      if ({clk_out, tick, pending} !== {exp_out, exp_tick, exp_pend}) begin
        failures++;
        $display("FAIL default_model edge %0d got %b/%b/%b want %b/%b/%b",
                 k, clk_out, tick, pending, exp_out, exp_tick, exp_pend);
      end
    end
    $display("test_default_toggle done");
  endtask

  task automatic test_pulse();
    apply_reset();
    div[0 +: W] = W'(4); mode[0] = 1'b1; load[0] = 1'b1;
    step();
    en[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      checks++;
      if (tick[0] !== (k % 4 == 0) || clk_out[0] !== tick[0]) begin
        failures++;
        $display("FAIL pulse edge %0d got tick=%b clk_out=%b want tick=%b clk_out=tick",
                 k, tick[0], clk_out[0], (k % 4 == 0));
      end
    end
    $display("test_pulse done");
  endtask

  task automatic test_midload();
    int pcount;
    apply_reset();
    mode = '0;
    en[0] = 1'b1;
    step(); step();
    div[0 +: W] = W'(3); load[0] = 1'b1;
    pcount = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (pending[0]) pcount++;
    end
    step();
    checks++;
    if (pcount != 3 || pending[0] !== 1'b0 || tick[0] !== 1'b1) begin
      failures++;
      $display("FAIL midload pending_cycles=%0d pending=%b tick=%b want 3/0/1", pcount, pending[0], tick[0]);
    end
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (tick[0] !== (k % 3 == 0)) begin
        failures++;
        $display("FAIL midload_newdiv edge %0d got tick=%b want %b", k, tick[0], (k % 3 == 0));
      end
    end
    apply_reset();
    en[0] = 1'b1;
    repeat (5) step();
    div[0 +: W] = W'(3); load[0] = 1'b1;
    step();
    checks++;
    if (pending[0] !== 1'b0 || tick[0] !== 1'b1) begin
      failures++;
      $display("FAIL boundary_load got pending=%b tick=%b want 0/1", pending[0], tick[0]);
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if (pending[0] !== 1'b0 || tick[0] !== (k == 3)) begin
        failures++;
        $display("FAIL boundary_load_next edge %0d got pending=%b tick=%b want 0/%b", k, pending[0], tick[0], (k == 3));
      end
    end
    $display("test_midload done");
  endtask

  task automatic test_corners();
    apply_reset();
    div[0 +: W] = W'(1); mode[0] = 1'b0; load[0] = 1'b1;
    step();
    en[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      checks++;
      if (clk_out[0] !== (k % 2 == 0) || tick[0] !== 1'b1) begin
        failures++;
        $display("FAIL div1_toggle edge %0d got clk_out=%b tick=%b want %b/1", k, clk_out[0], tick[0], (k % 2 == 0));
      end
    end
    en[0] = 1'b0;
    div[0 +: W] = W'(1); mode[0] = 1'b1; load[0] = 1'b1;
    step();
    en[0] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      checks++;
      if (tick[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
        failures++;
        $display("FAIL div1_pulse edge %0d got tick=%b clk_out=%b want 1/1", k, tick[0], clk_out[0]);
      end
    end
    div[0 +: W] = W'(0); mode[0] = 1'b0; load[0] = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0 || pending[0] !== 1'b0) begin
        failures++;
        $display("FAIL div0_stall edge %0d got tick=%b clk_out=%b pending=%b want 0/0/0", k, tick[0], clk_out[0], pending[0]);
      end
    end
    div[0 +: W] = W'(5); load[0] = 1'b1;
    step();
    checks++;
    if (pending[0] !== 1'b0) begin
      failures++;
      $display("FAIL div0_reload got pending=%b want 0", pending[0]);
    end
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 5)) begin
        failures++;
        $display("FAIL div0_reload_run edge %0d got tick=%b want %b", k, tick[0], (k == 5));
      end
    end
    $display("test_corners done");
  endtask

  task automatic test_en_drop();
    apply_reset();
    en[0] = 1'b1;
    repeat (3) step();
    en[0] = 1'b0;
    step();
    checks++;
    if (tick[0] !== 1'b0 || clk_out[0] !== 1'b0) begin
      failures++;
      $display("FAIL en_drop got tick=%b clk_out=%b want 0/0", tick[0], clk_out[0]);
    end
    en[0] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      checks++;
      if (tick[0] !== (k == 6)) begin
        failures++;
        $display("FAIL en_reraise edge %0d got tick=%b want %b", k, tick[0], (k == 6));
      end
    end
    step(); step();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (clk_out !== '0 || tick !== '0 || pending !== '0) begin
      failures++;
      $display("FAIL async_reset got clk_out=%b tick=%b pending=%b want 0", clk_out, tick, pending);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (tick[0] !== (k % 6 == 0)) begin
        failures++;
        $display("FAIL reset_div6 edge %0d got tick=%b want %b", k, tick[0], (k % 6 == 0));
      end
    end
    $display("test_en_drop done");
  endtask

  task automatic test_back_to_back();
    int bad;
    apply_reset();
    div[0 +: W] = W'(2); mode[0] = 1'b0;
    div[W +: W] = W'(7); mode[1] = 1'b1;
    load = 2'b11;
    step();
    en = 2'b11;
    bad = 0;
    for (int k = 0; k < 1000; k++) begin
      for (int c = 0; c < N_CH; c++) begin
        if ($urandom_range(0, 19) == 0) begin
          div[c*W +: W] = W'($urandom_range(0, 9));
          mode[c]       = 1'($urandom_range(0, 1));
          load[c]       = 1'b1;
        end
        if ($urandom_range(0, 49) == 0) en[c] = ~en[c];
      end
      step();
      checks++;
      if ({clk_out, tick, pending} !== {exp_out, exp_tick, exp_pend}) begin
        failures++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cycle %0d got out=%b tick=%b pend=%b want out=%b tick=%b pend=%b",
                   k, clk_out, tick, pending, exp_out, exp_tick, exp_pend);
      end
    end
    $display("test_back_to_back done, cycle mismatches=%0d", bad);
  endtask

  initial begin
    test_reset();
    test_default_toggle();
    test_pulse();
    test_midload();
    test_corners();
    test_en_drop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
